// File: rtl/alu_pkg.sv
// Shared opcode constants for the RV32I decoder, execute stage and ALU.
// Operation codes, branch flag levels and the alucode width.
package alu_pkg;

    localparam int ALUCODE_W = 6;
    localparam int XLEN      = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [ALUCODE_W-1:0] ALU_LUI  = 6'd0;
    localparam logic [ALUCODE_W-1:0] ALU_ADD  = 6'd1;
    localparam logic [ALUCODE_W-1:0] ALU_SUB  = 6'd2;
    localparam logic [ALUCODE_W-1:0] ALU_SLT  = 6'd3;
    localparam logic [ALUCODE_W-1:0] ALU_SLTU = 6'd4;
    localparam logic [ALUCODE_W-1:0] ALU_XOR  = 6'd5;
    localparam logic [ALUCODE_W-1:0] ALU_OR   = 6'd6;
    localparam logic [ALUCODE_W-1:0] ALU_AND  = 6'd7;
    localparam logic [ALUCODE_W-1:0] ALU_SLL  = 6'd8;
    localparam logic [ALUCODE_W-1:0] ALU_SRL  = 6'd9;
    localparam logic [ALUCODE_W-1:0] ALU_SRA  = 6'd10;
    localparam logic [ALUCODE_W-1:0] ALU_JAL  = 6'd11;
    localparam logic [ALUCODE_W-1:0] ALU_JALR = 6'd12;
    localparam logic [ALUCODE_W-1:0] ALU_BEQ  = 6'd13;
    localparam logic [ALUCODE_W-1:0] ALU_BNE  = 6'd14;
    localparam logic [ALUCODE_W-1:0] ALU_BLT  = 6'd15;
    localparam logic [ALUCODE_W-1:0] ALU_BGE  = 6'd16;
    localparam logic [ALUCODE_W-1:0] ALU_BLTU = 6'd17;
    localparam logic [ALUCODE_W-1:0] ALU_BGEU = 6'd18;
    localparam logic [ALUCODE_W-1:0] ALU_LB   = 6'd19;
    localparam logic [ALUCODE_W-1:0] ALU_LH   = 6'd20;
    localparam logic [ALUCODE_W-1:0] ALU_LW   = 6'd21;
    localparam logic [ALUCODE_W-1:0] ALU_LBU  = 6'd22;
    localparam logic [ALUCODE_W-1:0] ALU_LHU  = 6'd23;
    localparam logic [ALUCODE_W-1:0] ALU_SB   = 6'd24;
    localparam logic [ALUCODE_W-1:0] ALU_SH   = 6'd25;
    localparam logic [ALUCODE_W-1:0] ALU_SW   = 6'd26;

endpackage

// File: rtl/alu.sv
// RV32I integer ALU: combinational result/branch flag plus a
// one-cycle registered copy for lanes that pipeline the result.
module alu
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALUCODE_W-1:0] alucode,
    input  logic [XLEN-1:0]      op1,
    input  logic [XLEN-1:0]      op2,
    output logic [XLEN-1:0]      alu_result,
    output logic                 br_taken,
    output logic [XLEN-1:0]      alu_result_q,
    output logic                 br_taken_q
);

    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_link;
    logic [4:0]      w_shamt;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_eq;
    logic [XLEN-1:0] w_result;
    logic            w_br;
    logic [XLEN-1:0] r_result;
    logic            r_br;

    // Shared adders and the compare terms reused by SLT/SLTU and branches
    always_comb begin
        w_sum   = op1 + op2;
        w_diff  = op1 - op2;
        w_link  = op2 + 32'd4;
        w_shamt = op2[4:0];
        w_lt_s  = $signed(op1) < $signed(op2);
        w_lt_u  = op1 < op2;
        w_eq    = (op1 == op2);
    end

    // Result and branch-flag select; unassigned codes give 0/0
    always_comb begin
        w_result = '0;
        w_br     = DISABLE;
        unique case (alucode)
            ALU_LUI:  w_result = op2;
            ALU_ADD:  w_result = w_sum;
            ALU_SUB:  w_result = w_diff;
            ALU_SLT:  w_result = {31'd0, w_lt_s};
            ALU_SLTU: w_result = {31'd0, w_lt_u};
            ALU_XOR:  w_result = op1 ^ op2;
            ALU_OR:   w_result = op1 | op2;
            ALU_AND:  w_result = op1 & op2;
            ALU_SLL:  w_result = op1 << w_shamt;
            ALU_SRL:  w_result = op1 >> w_shamt;
            ALU_SRA:  w_result = $signed(op1) >>> w_shamt;
            ALU_JAL, ALU_JALR: begin
                w_result = w_link;
                w_br     = ENABLE;
            end
            ALU_BEQ:  w_br = w_eq;
            ALU_BNE:  w_br = ~w_eq;
            ALU_BLT:  w_br = w_lt_s;
            ALU_BGE:  w_br = ~w_lt_s;
            ALU_BLTU: w_br = w_lt_u;
            ALU_BGEU: w_br = ~w_lt_u;
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU,
            ALU_LHU, ALU_SB, ALU_SH, ALU_SW:
                      w_result = w_sum;
            default: begin
                w_result = '0;
                w_br     = DISABLE;
            end
        endcase
    end

    // Output register: capture every edge, reset overrides capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_br     <= DISABLE;
        end else begin
            r_result <= w_result;
            r_br     <= w_br;
        end
    end

    assign alu_result   = w_result;
    assign br_taken     = w_br;
    assign alu_result_q = r_result;
    assign br_taken_q   = r_br;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the RV32I ALU: directed vectors plus
// randomized operations against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [5:0]  alucode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] alu_result;
    logic        br_taken;
    logic [31:0] alu_result_q;
    logic        br_taken_q;

    int n_tests;
    int n_fail;

    typedef struct {
        string       name;
        logic [31:0] res_c;
        logic        br_c;
        logic [31:0] res_q;
        logic        br_q;
    } exp_t;

    exp_t sb_q[$];

    alu dut (
        .clk          (clk),
        .rst          (rst),
        .alucode      (alucode),
        .op1          (op1),
        .op2          (op2),
        .alu_result   (alu_result),
        .br_taken     (br_taken),
        .alu_result_q (alu_result_q),
        .br_taken_q   (br_taken_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check32(string nm, logic [31:0] act,
                                    logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endfunction

    function automatic void check1(string nm, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endfunction

    // Reference model from the operation table, using 64-bit arithmetic
    function automatic void model(input logic [5:0] c,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r,
                                  output logic br);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(ub % 32);
        r  = 32'd0;
        br = 1'b0;
        case (int'(c)) inside
            0:  r = b;
            1:  r = 32'((ua + ub) % 64'h1_0000_0000);
            2:  r = 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
            3:  r = (sa < sb) ? 32'd1 : 32'd0;
            4:  r = (ua < ub) ? 32'd1 : 32'd0;
            5:  r = a ^ b;
            6:  r = a | b;
            7:  r = a & b;
            8:  r = 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
            9:  r = 32'(ua / (64'd1 << sh));
            10: r = 32'(sa >>> sh);
            11, 12: begin
                r  = 32'((ub + 4) % 64'h1_0000_0000);
                br = 1'b1;
            end
            13: br = (ua == ub);
            14: br = (ua != ub);
            15: br = (sa < sb);
            16: br = (sa >= sb);
            17: br = (ua < ub);
            18: br = (ua >= ub);
            [19:26]: r = 32'((ua + ub) % 64'h1_0000_0000);
            default: begin
                r  = 32'd0;
                br = 1'b0;
            end
        endcase
    endfunction

    task automatic issue(string nm, logic r, logic [5:0] c,
                         logic [31:0] a, logic [31:0] b,
                         logic [31:0] er, logic eb);
        exp_t e;
        @(negedge clk);
        rst     = r;
        alucode = c;
        op1     = a;
        op2     = b;
        e.name  = nm;
        e.res_c = er;
        e.br_c  = eb;
        e.res_q = r ? 32'd0 : er;
        e.br_q  = r ? 1'b0 : eb;
        sb_q.push_back(e);
    endtask

    task automatic issue_rand(logic r, logic [5:0] c,
                              logic [31:0] a, logic [31:0] b);
        logic [31:0] er;
        logic        eb;
        model(c, a, b, er, eb);
        issue($sformatf("rnd_op%0d", c), r, c, a, b, er, eb);
    endtask

    // Monitor: after each edge, compare both output views to the oldest entry
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check32({e.name, "_res"}, alu_result, e.res_c);
                check1({e.name, "_br"}, br_taken, e.br_c);
                check32({e.name, "_res_q"}, alu_result_q, e.res_q);
                check1({e.name, "_br_q"}, br_taken_q, e.br_q);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic        r;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        alucode = 6'd0;
        op1     = 32'd0;
        op2     = 32'd0;

        issue("reset0", 1, 6'd1, 32'd34, 32'd55, 32'd89, 1'b0);
        issue("reset1", 1, 6'd1, 32'd34, 32'd55, 32'd89, 1'b0);

        issue("add",   0, 6'd1, 32'd34, 32'd55, 32'd89, 1'b0);
        issue("sub",   0, 6'd2, 32'd55, 32'd56, 32'hFFFFFFFF, 1'b0);
        issue("slt",   0, 6'd3, 32'hFEEDFACE, 32'hBADCAB1E, 32'd0, 1'b0);
        issue("sltu",  0, 6'd4, 32'hBADCAB1E, 32'hFEEDFACE, 32'd1, 1'b0);
        issue("xor",   0, 6'd5, 32'hBADCAB1E, 32'hFEEDFACE,
              32'h443151D0, 1'b0);
        issue("or",    0, 6'd6, 32'hBADCAB1E, 32'hFEEDFACE,
              32'hFEFDFBDE, 1'b0);
        issue("and",   0, 6'd7, 32'hBADCAB1E, 32'hFEEDFACE,
              32'hBACCAA0E, 1'b0);
        issue("sll",   0, 6'd8, 32'hFEEDFACE, 32'd1036, 32'hDFACE000, 1'b0);
        issue("srl",   0, 6'd9, 32'hDEADDEAD, 32'd16, 32'h0000DEAD, 1'b0);
        issue("sra",   0, 6'd10, 32'hDEADDEAD, 32'd16, 32'hFFFFDEAD, 1'b0);
        issue("jal",   0, 6'd11, 32'h1234, 32'h40000, 32'h40004, 1'b1);
        issue("jalr",  0, 6'd12, 32'h9999, 32'h50000, 32'h50004, 1'b1);
        issue("beq_ne", 0, 6'd13, 32'hBAADF00D, 32'hBAADCAFE, 32'd0, 1'b0);
        issue("beq_eq", 0, 6'd13, 32'h77, 32'h77, 32'd0, 1'b1);
        issue("bne_eq", 0, 6'd14, 32'h77, 32'h77, 32'd0, 1'b0);
        issue("bne_ne", 0, 6'd14, 32'd1, 32'd2, 32'd0, 1'b1);
        issue("blt_a", 0, 6'd15, 32'h100, 32'h123, 32'd0, 1'b1);
        issue("blt_b", 0, 6'd15, 32'h100, 32'hFEE1DEAD, 32'd0, 1'b0);
        issue("bge_a", 0, 6'd16, 32'h100, 32'h123, 32'd0, 1'b0);
        issue("bge_b", 0, 6'd16, 32'h100, 32'hFEE1DEAD, 32'd0, 1'b1);
        issue("bltu_a", 0, 6'd17, 32'h100, 32'hFEE1DEAD, 32'd0, 1'b1);
        issue("bltu_b", 0, 6'd17, 32'hFFFFFFFF, 32'hFEE1DEAD, 32'd0, 1'b0);
        issue("bgeu_a", 0, 6'd18, 32'h100, 32'hFEE1DEAD, 32'd0, 1'b0);
        issue("bgeu_b", 0, 6'd18, 32'hFFFFFFFF, 32'hFEE1DEAD, 32'd0, 1'b1);
        issue("lb",    0, 6'd19, 32'd1, 32'd1, 32'd2, 1'b0);
        issue("lw",    0, 6'd21, 32'd2, 32'd3, 32'd5, 1'b0);
        issue("sw",    0, 6'd26, 32'd21, 32'd34, 32'd55, 1'b0);
        issue("lui",   0, 6'd0, 32'hDEAD, 32'd5054464, 32'd5054464, 1'b0);
        issue("unasg", 0, 6'd63, 32'h12, 32'h34, 32'd0, 1'b0);

        issue("pipe_add", 0, 6'd1, 32'd34, 32'd55, 32'd89, 1'b0);
        issue("mid_rst",  1, 6'd1, 32'd34, 32'd55, 32'd89, 1'b0);
        issue("post_rst", 0, 6'd11, 32'd0, 32'h100, 32'h104, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8)
                c = 6'($urandom_range(0, 26));
            else
                c = 6'($urandom_range(27, 63));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = 32'($urandom_range(0, 64));
                default: b = $urandom;
            endcase
            r = ($urandom_range(0, 19) == 0);
            issue_rand(r, c, a, b);
        end

        for (int i = 0; i < 10 && sb_q.size() != 0; i++)
            @(posedge clk);
        #2;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Combinational RV32I integer ALU for the execute stage of each superscalar issue lane. It computes arithmetic, logical, shift, address and link results, and evaluates branch conditions from a 6-bit ALU opcode and two 32-bit operands. A one-cycle registered copy of both outputs is provided for lanes that pipeline the result.

## Interface
Parameters:
- none. Widths are fixed: 32-bit datapath, 6-bit alucode.

Ports:
- clk  in  1  single clock, rising-edge; used only by the output register.
- rst  in  1  synchronous, active-high reset; clears the output register only.
- alucode  in  6  operation select (`ALU_*` constants).
- op1  in  32  operand 1 (rs1 value, or ignored for jumps/LUI).
- op2  in  32  operand 2 (rs2 value, immediate, or PC for jumps).
- alu_result  out  32  combinational result.
- br_taken  out  1  combinational branch/jump-taken flag (`ENABLE`=1, `DISABLE`=0).
- alu_result_q  out  32  alu_result registered on clk.
- br_taken_q  out  1  br_taken registered on clk.

## Operation
Encodings (decimal):
- LUI 0, ADD 1, SUB 2, SLT 3, SLTU 4, XOR 5, OR 6, AND 7, SLL 8, SRL 9, SRA 10.
- JAL 11, JALR 12, BEQ 13, BNE 14, BLT 15, BGE 16, BLTU 17, BGEU 18.
- LB 19, LH 20, LW 21, LBU 22, LHU 23, SB 24, SH 25, SW 26.

Results:
- ADD: op1+op2. SUB: op1−op2. Both mod 2^32, with no carry or overflow output.
- SLT: 1 if $signed(op1) < $signed(op2), else 0. SLTU: the unsigned equivalent. Bits [31:1] are always 0.
- XOR, OR, AND: bitwise.
- SLL, SRL, SRA: shift op1 by op2[4:0]. Upper bits of op2 are ignored, so 1036 shifts by 12. SRA replicates op1[31].
- JAL, JALR: result = op2+4 (link address; op2 carries the PC). br_taken=1. op1 is ignored.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: result = 0. br_taken = the RISC-V condition on op1 vs op2. BLT/BGE compare signed; the U variants compare unsigned.
- Loads and stores (LB…SW): result = op1+op2 (effective address). br_taken=0.
- LUI: result = op2 (the pre-shifted immediate). op1 is ignored.
- br_taken is 0 for every non-branch, non-jump code.
- Unassigned codes (27–63): result 0, br_taken 0.
- The combinational path must be free of latches. Every output is assigned on every path, with a default arm.

## Timing
- alu_result and br_taken are purely combinational: zero latency, valid within the same cycle that inputs settle.
- alu_result_q and br_taken_q capture the combinational outputs on every rising clk edge, giving 1-cycle latency. There is no enable and no stall input.
- On a rising edge with rst=1: alu_result_q=0 and br_taken_q=0, overriding the capture.
- Reset asserted mid-stream clears the registered outputs on that edge only. It has no effect on the combinational outputs.
- Reset values: alu_result_q 0, br_taken_q 0. The combinational outputs have no reset value; they follow the inputs at all times.

## Structure
- `ALU_*` opcode constants, `ENABLE`/`DISABLE` and the alucode width belong in the shared define header/package already used by decoder and execute. They must not be redefined locally.
- A single module is sufficient. There is no sub-module: the compare logic is a shared signed/unsigned less-than plus an equality term, reused by SLT/SLTU and the branches.

## Test plan
- Arithmetic:
  - ADD 34,55 -> 89, br 0.
  - SUB 55,56 -> 0xFFFFFFFF.
  - SLT 0xFEEDFACE,0xBADCAB1E -> 0.
  - SLTU 0xBADCAB1E,0xFEEDFACE -> 1.
- Logic and shifts:
  - XOR 0xBADCAB1E,0xFEEDFACE -> 0x443151D0.
  - OR (same operands) -> 0xFEFDFBDE.
  - AND (same operands) -> 0xBACCAA0E.
  - SLL 0xFEEDFACE by 1036 -> 0xDFACE000.
  - SRL 0xDEADDEAD by 16 -> 0x0000DEAD.
  - SRA 0xDEADDEAD by 16 -> 0xFFFFDEAD.
- Jumps:
  - JAL op2=0x40000 -> result 0x40004, br 1.
  - JALR op2=0x50000 -> result 0x50004, br 1.
- Branches (all must give result 0):
  - BEQ 0xBAADF00D vs 0xBAADCAFE -> 0; equal operands -> 1.
  - BNE equal operands -> 0.
  - BLT 0x100 vs 0x123 -> 1; 0x100 vs 0xFEE1DEAD -> 0.
  - BLTU 0x100 vs 0xFEE1DEAD -> 1; 0xFFFFFFFF vs 0xFEE1DEAD -> 0.
  - BGE and BGEU give the complements of BLT and BLTU.
- Memory and LUI:
  - LB 1+1 -> 2, LW 2+3 -> 5, SW 21+34 -> 55, each with br 0.
  - LUI op2=5054464 -> 5054464.
  - Unassigned code 63 -> 0/0.
- Register stage:
  - Apply ADD 34,55 and clock once -> alu_result_q=89.
  - Assert rst on the next edge -> alu_result_q=0, br_taken_q=0, while combinational alu_result stays 89.
